// File: rtl/shift_add_mult_ctrl.sv
// ---------------------------------------------------------------------------
// shift_add_mult_ctrl
//   Sequential unsigned shift-and-add multiplier for the mantissa-product path.
//   One WIDTH-bit ripple adder is reused for every partial product. Each ADD
//   cycle performs one conditional add and one right shift of {carry, A, Q}.
//   Latency is WIDTH+1 cycles from the accepting edge to DONE. The product and
//   o_valid are registered, so they appear one cycle later, in the same cycle
//   that o_ready returns high.
//
// Ports
//   i_clk      clock; all state updates on the rising edge
//   i_rst      synchronous active-high reset
//   i_start    request, sampled only while o_ready=1
//   i_mcand    multiplicand, captured on an accepted start
//   i_mplier   multiplier, captured on an accepted start
//   o_ready    high while the controller is idle
//   o_valid    one-cycle pulse; o_product is new in this cycle
//   o_product  2*WIDTH-bit unsigned product
// ---------------------------------------------------------------------------

// Plain carry-chain adder with carry-out. Carry-in is tied to zero.
module ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c
);
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        assign o_sum[gi]   = i_add1[gi] ^ i_add2[gi] ^ carry[gi];
        assign carry[gi+1] = (i_add1[gi] & i_add2[gi]) |
                             (carry[gi] & (i_add1[gi] ^ i_add2[gi]));
    end

    assign o_c = carry[WIDTH];
endmodule

module shift_add_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_mcand,
    input  logic [WIDTH-1:0]     i_mplier,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [2*WIDTH-1:0]   o_product
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     rm_q, rm_d;       // multiplicand
    logic [WIDTH-1:0]     ra_q, ra_d;       // upper accumulator
    logic [WIDTH-1:0]     rq_q, rq_d;       // multiplier, becomes low product half
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 carry_out;

    // The multiplier LSB selects whether this iteration adds the multiplicand.
    assign addend = rq_q[0] ? rm_q : '0;

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .i_add1 (ra_q),
        .i_add2 (addend),
        .o_sum  (sum),
        .o_c    (carry_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            rm_q      <= '0;
            ra_q      <= '0;
            rq_q      <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            rm_q      <= rm_d;
            ra_q      <= ra_d;
            rq_q      <= rq_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rm_d      = rm_q;
        ra_d      = ra_q;
        rq_d      = rq_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    rm_d    = i_mcand;
                    ra_d    = '0;
                    rq_d    = i_mplier;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                // The carry-out goes into the accumulator MSB, so no
                // product bit is lost. The sum LSB shifts into Q.
                ra_d  = {carry_out, sum[WIDTH-1:1]};
                rq_d  = {sum[0], rq_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                product_d = {ra_q, rq_q};
                valid_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_valid   = valid_q;
    assign o_product = product_q;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mult_ctrl
//   This bench drives two instances of the multiplier, one with WIDTH=8 and
//   one with WIDTH=24, from the same clock and reset. The reference model is
//   plain integer multiplication. The model also tracks the last published
//   product, which is used to check that o_product holds between results.
// ---------------------------------------------------------------------------
module tb_shift_add_mult_ctrl;
    logic        clk = 1'b0;
    logic        rst;

    logic        start8;
    logic [7:0]  mcand8, mplier8;
    logic        ready8, valid8;
    logic [15:0] product8;

    logic        start24;
    logic [23:0] mcand24, mplier24;
    logic        ready24, valid24;
    logic [47:0] product24;

    int checks   = 0;
    int failures = 0;

    logic [15:0] last8;   // model: product currently published by the 8-bit unit
    logic [47:0] last24;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(8)) u_dut8 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start8),
        .i_mcand   (mcand8),
        .i_mplier  (mplier8),
        .o_ready   (ready8),
        .o_valid   (valid8),
        .o_product (product8)
    );

    shift_add_mult_ctrl #(.WIDTH(24)) u_dut24 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start24),
        .i_mcand   (mcand24),
        .i_mplier  (mplier24),
        .o_ready   (ready24),
        .o_valid   (valid24),
        .o_product (product24)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, then presents operands for one cycle. Afterwards the
    // operand inputs are scrambled to show that the captured copy is used.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        while (!ready8 && guard < 50) begin
            step();
            guard++;
        end
        check("ready8_wait", 64'(ready8), 64'd1);
        mcand8  = a;
        mplier8 = b;
        start8  = 1'b1;
        step();
        start8  = 1'b0;
        mcand8  = 8'($urandom);
        mplier8 = 8'($urandom);
        $display("op8  %0d*%0d issued", a, b);
        check("ready8_fall", 64'(ready8), 64'd0);
    endtask

    // Entered in cycle 1. The product is expected in cycle WIDTH+2 = 10.
    // Optionally pulses ignored 7*7 starts in cycles 3 and 6.
    task automatic wait8(input string tag, input logic [15:0] exp, input bit pulse_ign);
        int cyc = 1;
        while (!valid8 && cyc < 40) begin
            check({tag, "_hold"}, 64'(product8), 64'(last8));
            if (pulse_ign && (cyc == 3 || cyc == 6)) begin
                start8  = 1'b1;
                mcand8  = 8'd7;
                mplier8 = 8'd7;
            end else begin
                start8 = 1'b0;
            end
            step();
            cyc++;
        end
        start8 = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd10);
        check({tag, "_valid"}, 64'(valid8), 64'd1);
        check({tag, "_ready"}, 64'(ready8), 64'd1);
        check({tag, "_product"}, 64'(product8), 64'(exp));
        last8 = exp;
        $display("op8  %s product=%0h expected=%0h cycle=%0d", tag, product8, exp, cyc);
    endtask

    // Confirms that o_valid is a single-cycle pulse when no new start follows.
    task automatic after8(input string tag);
        step();
        check({tag, "_pulse_end"}, 64'(valid8), 64'd0);
        check({tag, "_held"}, 64'(product8), 64'(last8));
    endtask

    task automatic op24(input string tag, input logic [23:0] a, input logic [23:0] b, input bit verbose);
        logic [47:0] exp;
        int cyc = 1;
        int guard = 0;
        exp = 48'(a) * 48'(b);
        while (!ready24 && guard < 60) begin
            step();
            guard++;
        end
        mcand24  = a;
        mplier24 = b;
        start24  = 1'b1;
        step();
        start24  = 1'b0;
        mcand24  = 24'($urandom);
        mplier24 = 24'($urandom);
        while (!valid24 && cyc < 60) begin
            if (product24 !== last24) check({tag, "_hold"}, 64'(product24), 64'(last24));
            step();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd26);
        check({tag, "_product"}, 64'(product24), 64'(exp));
        last24 = exp;
        if (verbose)
            $display("op24 %s %0h*%0h product=%0h expected=%0h cycle=%0d", tag, a, b, product24, exp, cyc);
    endtask

    initial begin
        logic [7:0] ra8, rb8;
        logic [23:0] ra24, rb24;

        rst = 1'b1;
        start8 = 1'b0;  mcand8 = '0;  mplier8 = '0;
        start24 = 1'b0; mcand24 = '0; mplier24 = '0;
        last8 = '0;
        last24 = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_ready8", 64'(ready8), 64'd1);
        check("rst_valid8", 64'(valid8), 64'd0);
        check("rst_product8", 64'(product8), 64'd0);
        check("rst_ready24", 64'(ready24), 64'd1);
        check("rst_product24", 64'(product24), 64'd0);
        $display("reset state checked");

        issue8(8'd13, 8'd11);
        wait8("m13x11", 16'h008F, 1'b0);
        after8("m13x11");

        issue8(8'hFF, 8'hFF);
        wait8("mffxff", 16'hFE01, 1'b0);
        after8("mffxff");

        // A zero operand still takes the full latency, and the previous
        // nonzero product stays visible until the new o_valid.
        issue8(8'd0, 8'hA5);
        wait8("m0xa5", 16'h0000, 1'b0);
        after8("m0xa5");
        issue8(8'd9, 8'd9);
        wait8("m9x9", 16'd81, 1'b0);
        issue8(8'hA5, 8'd0);
        wait8("ma5x0", 16'h0000, 1'b0);
        after8("ma5x0");

        // Starts issued while busy are ignored. The next start is
        // issued in the o_valid cycle.
        issue8(8'd3, 8'd5);
        wait8("m3x5", 16'd15, 1'b1);
        issue8(8'd7, 8'd7);
        wait8("m7x7_b2b", 16'd49, 1'b0);
        after8("m7x7_b2b");

        // Reset in cycle 4 of a 200*100 request
        issue8(8'd200, 8'd100);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last8 = '0;
        check("abort_ready", 64'(ready8), 64'd1);
        check("abort_product", 64'(product8), 64'd0);
        for (int i = 0; i < 15; i++) begin
            if (valid8 !== 1'b0) check("abort_no_valid", 64'(valid8), 64'd0);
            step();
        end
        check("abort_no_valid_end", 64'(valid8), 64'd0);
        $display("op8  abort 200*100 product=%0h", product8);
        issue8(8'd2, 8'd3);
        wait8("m2x3", 16'd6, 1'b0);
        after8("m2x3");

        for (int i = 0; i < 200; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            issue8(ra8, rb8);
            wait8("rand8", 16'(ra8) * 16'(rb8), 1'b0);
        end

        op24("m800000sq", 24'h800000, 24'h800000, 1'b1);
        op24("mffffffsq", 24'hFFFFFF, 24'hFFFFFF, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            ra24 = 24'($urandom);
            rb24 = 24'($urandom);
            op24("rand24", ra24, rb24, (i < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
